// File: rtl/evt_stream_distributor_pkg.sv
// Shared SNE event types, distributor FSM states and FIFO depth bounds.
package evt_stream_distributor_pkg;

   localparam int unsigned DIST_FIFO_DEPTH_MIN = 2;
   localparam int unsigned DIST_FIFO_DEPTH_MAX = 4;

   typedef struct packed {
      logic [3:0]  op;
      logic [11:0] addr;
   } sne_evt_t;

   typedef enum logic {
      DIST_ROUTE = 1'b0,
      DIST_DRAIN = 1'b1
   } dist_state_e;

   // Keeps an out-of-range FIFO_DEPTH from producing a broken pointer width.
   function automatic int unsigned dist_depth_clamp(input int unsigned depth);
      if (depth < DIST_FIFO_DEPTH_MIN) return DIST_FIFO_DEPTH_MIN;
      if (depth > DIST_FIFO_DEPTH_MAX) return DIST_FIFO_DEPTH_MAX;
      return depth;
   endfunction

endpackage

// File: rtl/SNE_EVENT_STREAM.sv
// Valid/ready event stream carrying one SNE event per handshake.
interface SNE_EVENT_STREAM;
   import evt_stream_distributor_pkg::*;

   logic     valid;
   logic     ready;
   sne_evt_t evt;

   modport src (output valid, output evt, input ready);
   modport dst (input valid, input evt, output ready);

endinterface

// File: rtl/evt_stream_distributor_slice.sv
// One distributor slice: small FIFO, ROUTE/DRAIN FSM and output path select.
module evt_stream_distributor_slice
   import evt_stream_distributor_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   SNE_EVENT_STREAM.dst evt_dst,
   SNE_EVENT_STREAM.src evt_arb_src,
   SNE_EVENT_STREAM.src evt_xbar_src,
   output logic         busy_o
);

   localparam int unsigned Depth = dist_depth_clamp(FIFO_DEPTH);
   localparam int unsigned PtrW  = $clog2(Depth);
   localparam int unsigned CntW  = $clog2(Depth + 1);

   localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
   localparam logic [CntW-1:0] CntFull = CntW'(Depth);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   sne_evt_t        mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   dist_state_e     state_q, state_d;
   logic            sel_q, sel_d;
   logic            run_q;

   logic     full, empty, mismatch;
   logic     in_ready, out_valid, out_ready;
   logic     push, pop;
   sne_evt_t head;

   assign full     = (cnt_q == CntFull);
   assign empty    = (cnt_q == '0);
   assign mismatch = (enable_i != sel_q);

   // run_q holds input ready low for the first cycle after reset.
   assign in_ready  = run_q && !rst_i && (state_q == DIST_ROUTE) && !full && !mismatch;
   assign out_valid = !rst_i && !empty;
   assign out_ready = sel_q ? evt_arb_src.ready : evt_xbar_src.ready;
   assign push      = in_ready && evt_dst.valid;
   assign pop       = out_valid && out_ready;
   assign head      = mem_q[rd_ptr_q];

   assign busy_o = !empty || (state_q == DIST_DRAIN) || mismatch;

   always_comb begin
      evt_dst.ready      = in_ready;
      evt_arb_src.valid  = 1'b0;
      evt_arb_src.evt    = '0;
      evt_xbar_src.valid = 1'b0;
      evt_xbar_src.evt   = '0;
      if (sel_q) begin
         evt_arb_src.valid = out_valid;
         evt_arb_src.evt   = head;
      end else begin
         evt_xbar_src.valid = out_valid;
         evt_xbar_src.evt   = head;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      state_d  = state_q;
      sel_d    = sel_q;

      if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;

      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CntOne;
         2'b01:   cnt_d = cnt_q - CntOne;
         default: cnt_d = cnt_q;
      endcase

      // The path only changes once the old path has carried every buffered event.
      unique case (state_q)
         DIST_ROUTE: if (mismatch) state_d = DIST_DRAIN;
         DIST_DRAIN: begin
            if (cnt_d == '0) begin
               state_d = DIST_ROUTE;
               sel_d   = enable_i;
            end
         end
         default: state_d = DIST_ROUTE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         state_q  <= DIST_ROUTE;
         sel_q    <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         state_q  <= state_d;
         sel_q    <= sel_d;
         run_q    <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= evt_dst.evt;
   end

endmodule

// File: rtl/evt_stream_distributor.sv
// Routes each engine event stream to the arbiter or crossbar path, one slice per stream.
module evt_stream_distributor #(
   parameter int unsigned SLICE_NUMBER = 8,
   parameter int unsigned FIFO_DEPTH   = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [SLICE_NUMBER-1:0] enable_i,
   SNE_EVENT_STREAM.dst            evt_stream_engine_dst   [SLICE_NUMBER-1:0],
   SNE_EVENT_STREAM.src            evt_stream_arbiter_src  [SLICE_NUMBER-1:0],
   SNE_EVENT_STREAM.src            evt_stream_crossbar_src [SLICE_NUMBER-1:0],
   output logic [SLICE_NUMBER-1:0] busy_o
);

   for (genvar i = 0; i < SLICE_NUMBER; i++) begin : g_slice
      evt_stream_distributor_slice #(
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_slice (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .enable_i     (enable_i[i]),
         .evt_dst      (evt_stream_engine_dst[i]),
         .evt_arb_src  (evt_stream_arbiter_src[i]),
         .evt_xbar_src (evt_stream_crossbar_src[i]),
         .busy_o       (busy_o[i])
      );
   end

endmodule

// File: doc/evt_stream_distributor.md
EVT_STREAM_DISTRIBUTOR -- requirements
Module: evt_stream_distributor

Interface
REQ-001 SHALL have parameter SLICE_NUMBER, default 8: number of independent slices.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: per-slice buffer entries, legal values 2..4.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable_i  input  SLICE_NUMBER  per-slice route request: 1 = arbiter path, 0 = crossbar path.
REQ-006 SHALL have port evt_stream_engine_dst  SNE_EVENT_STREAM.dst  [SLICE_NUMBER-1:0]  engine output events, input side.
REQ-007 SHALL have port evt_stream_arbiter_src  SNE_EVENT_STREAM.src  [SLICE_NUMBER-1:0]  events routed to the arbiter path.
REQ-008 SHALL have port evt_stream_crossbar_src  SNE_EVENT_STREAM.src  [SLICE_NUMBER-1:0]  events routed to the crossbar path.
REQ-009 SHALL have port busy_o  output  SLICE_NUMBER  slice i has buffered events or a route switch pending.

Function
REQ-010 Each slice SHALL operate independently; there is no cross-slice interaction.
REQ-011 An input handshake SHALL occur when valid and ready are both 1 on a rising edge; the full event payload is pushed into the slice FIFO.
REQ-012 Input ready SHALL be 1 only when the state is ROUTE and the FIFO is not full; it SHALL NOT depend on any output ready (no combinational ready path).
REQ-013 The FIFO head SHALL drive only the output selected by sel_q; the unselected output SHALL hold valid at 0 with payload at 0.
REQ-014 The selected output valid SHALL equal FIFO not-empty, and payload SHALL equal the FIFO head.
REQ-015 Payload SHALL stay stable while valid is 1 and ready is 0.
REQ-016 Latency SHALL be 1 cycle: an event accepted at edge N is valid at the output after edge N.
REQ-017 Throughput SHALL be 1 event/cycle when the FIFO is not full and the output ready is 1.
REQ-018 When full, no push SHALL occur even if a pop occurs in the same cycle; a simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL span 0..FIFO_DEPTH.
REQ-020 Each slice SHALL have a 2-state FSM, ROUTE and DRAIN.
REQ-021 ROUTE->DRAIN SHALL occur when enable_i[i] != sel_q; input ready SHALL be 0 from that cycle onward.
REQ-022 In DRAIN, buffered events SHALL continue to leave on the old path.
REQ-023 DRAIN->ROUTE SHALL occur on the edge where the count is 0 (after any pop in that cycle); on that edge sel_q <= enable_i[i].
REQ-024 If enable_i[i] returns to sel_q while in DRAIN, the FSM SHALL still complete the drain and then return to ROUTE with sel_q unchanged.
REQ-025 A DRAIN entered with an empty FIFO SHALL last exactly 1 cycle.
REQ-026 busy_o[i] SHALL be (count != 0) or (state == DRAIN) or (enable_i[i] != sel_q).
REQ-027 No event SHALL ever be duplicated, dropped, reordered, or delivered on both paths.

Reset
REQ-028 While rst_i = 1 at an edge: count = 0, pointers = 0, state = ROUTE, sel_q = 0 (crossbar).
REQ-029 During reset and on the first cycle after it: input ready = 0, both output valids = 0, busy_o = 0 if enable_i = 0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered events with no output handshake.
REQ-031 FIFO storage SHALL NOT require reset.

Structure
REQ-032 The shared SNE event package SHALL hold the FSM state enum (DIST_ROUTE, DIST_DRAIN) and the FIFO depth bound constant.
REQ-033 The block SHALL instantiate one sub-module per slice, evt_stream_distributor_slice, containing the FIFO, FSM and output muxing; the top level is a generate loop only.

Verification
REQ-034 SLICE_NUMBER=2, enable=0: push 3 events A,B,C with crossbar ready=1 -> A,B,C appear on crossbar on consecutive cycles, 1-cycle latency, arbiter valid=0 throughout.
REQ-035 Crossbar ready=0, push 2 events -> input ready falls to 0 after the 2nd; 3rd event held; when ready=1, all 3 are delivered in order.
REQ-036 2 events buffered, crossbar ready=0, enable 0->1 -> input ready=0, busy=1; release ready -> both exit on crossbar, then sel=arbiter, next event exits on arbiter.
REQ-037 Empty FIFO, enable toggles 0->1 -> exactly 1 DRAIN cycle, then input ready=1 and routing to arbiter.
REQ-038 Reset pulsed with 2 events buffered -> both outputs valid=0 next cycle; the events never appear.
REQ-039 Random valid/ready/enable on 8 slices for 10k cycles -> scoreboard shows no loss, duplication or reordering per slice, and the path matches sel at dequeue.
